// File: rtl/alu_op_sequencer.sv
// Two-port round-robin front end for the shared 5-bit ALU: latches one request,
// holds it on the ALU for a settle window, and returns Y/Y1 to the owning port.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [9:0]  req_a,
  input  logic [9:0]  req_b,
  input  logic [11:0] req_ctrl,
  input  logic [11:0] req_shift,
  input  logic [31:0] req_imm,
  output logic [4:0]  alu_a,
  output logic [4:0]  alu_b,
  output logic [5:0]  alu_ctrl,
  output logic [5:0]  alu_shift,
  output logic [15:0] alu_imm,
  output logic        alu_busy,
  input  logic [4:0]  alu_y,
  input  logic [4:0]  alu_y1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [4:0]  rsp_y,
  output logic [4:0]  rsp_y1,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_r;
  logic        last_grant_r;
  logic        owner_r;
  logic [3:0]  cnt_r;

  logic [1:0]  grant_s;
  logic        acc_port_s;
  logic        accept_s;
  logic [4:0]  sel_a_s;
  logic [4:0]  sel_b_s;
  logic [5:0]  sel_ctrl_s;
  logic [5:0]  sel_shift_s;
  logic [15:0] sel_imm_s;

  function automatic logic ctrl_legal(input logic [5:0] code);
    case (code)
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110,
      6'b001010, 6'b001011: ctrl_legal = 1'b1;
      default:              ctrl_legal = 1'b0;
    endcase
  endfunction

  // Round-robin grant and operand mux for the granted port
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
    acc_port_s = grant_s[1];
    if (acc_port_s) begin
      sel_a_s     = req_a[9:5];
      sel_b_s     = req_b[9:5];
      sel_ctrl_s  = req_ctrl[11:6];
      sel_shift_s = req_shift[11:6];
      sel_imm_s   = req_imm[31:16];
    end else begin
      sel_a_s     = req_a[4:0];
      sel_b_s     = req_b[4:0];
      sel_ctrl_s  = req_ctrl[5:0];
      sel_shift_s = req_shift[5:0];
      sel_imm_s   = req_imm[15:0];
    end
  end

  // Ready is offered only in IDLE; forced low while reset is asserted
  always_comb begin
    if ((state_r == IDLE) && !rst) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
    accept_s = |(req_valid & req_ready);
  end

  // Sequencer FSM with registered ALU and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      cnt_r        <= 4'd0;
      alu_a        <= 5'd0;
      alu_b        <= 5'd0;
      alu_ctrl     <= 6'd0;
      alu_shift    <= 6'd0;
      alu_imm      <= 16'd0;
      alu_busy     <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_y        <= 5'd0;
      rsp_y1       <= 5'd0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            owner_r      <= acc_port_s;
            last_grant_r <= acc_port_s;
            // Rejected codes never reach the ALU inputs
            if (ctrl_legal(sel_ctrl_s)) begin
              alu_a     <= sel_a_s;
              alu_b     <= sel_b_s;
              alu_ctrl  <= sel_ctrl_s;
              alu_shift <= sel_shift_s;
              alu_imm   <= sel_imm_s;
              alu_busy  <= 1'b1;
              cnt_r     <= 4'd0;
              state_r   <= EXEC;
            end else begin
              rsp_err <= 1'b1;
              rsp_y   <= 5'd0;
              rsp_y1  <= 5'd0;
              state_r <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt_r == CNT_LAST) begin
            rsp_y    <= alu_y;
            rsp_y1   <= alu_y1;
            rsp_err  <= 1'b0;
            alu_busy <= 1'b0;
            cnt_r    <= 4'd0;
            state_r  <= RESP;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        RESP: begin
          // First RESP cycle raises valid; later cycles wait for the owner's ready
          if (rsp_valid == 2'b00) begin
            rsp_valid <= owner_r ? 2'b10 : 2'b01;
          end else if (rsp_ready[owner_r]) begin
            rsp_valid <= 2'b00;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table plus scoreboard,
// with hand-written arbitration, backpressure and reset-mid-EXEC sequences.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4;
  logic [1:0]  req_valid, rsp_ready;
  logic [9:0]  req_a, req_b;
  logic [11:0] req_ctrl, req_shift;
  logic [31:0] req_imm;

  logic [1:0]  r1_req_ready, r1_rsp_valid, r4_req_ready, r4_rsp_valid;
  logic [4:0]  r1_alu_a, r1_alu_b, r1_y, r1_y1, r1_rsp_y, r1_rsp_y1;
  logic [4:0]  r4_alu_a, r4_alu_b, r4_y, r4_y1, r4_rsp_y, r4_rsp_y1;
  logic [5:0]  r1_alu_ctrl, r1_alu_shift, r4_alu_ctrl, r4_alu_shift;
  logic [15:0] r1_alu_imm, r4_alu_imm;
  logic        r1_alu_busy, r1_rsp_err, r4_alu_busy, r4_rsp_err;

  // ALU stubs: Y = A+B, Y1 = A-B, both mod 32
  assign r1_y  = r1_alu_a + r1_alu_b;
  assign r1_y1 = r1_alu_a - r1_alu_b;
  assign r4_y  = r4_alu_a + r4_alu_b;
  assign r4_y1 = r4_alu_a - r4_alu_b;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid), .req_ready(r1_req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_shift(req_shift),
    .req_imm(req_imm), .alu_a(r1_alu_a), .alu_b(r1_alu_b), .alu_ctrl(r1_alu_ctrl),
    .alu_shift(r1_alu_shift), .alu_imm(r1_alu_imm), .alu_busy(r1_alu_busy),
    .alu_y(r1_y), .alu_y1(r1_y1), .rsp_valid(r1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(r1_rsp_y), .rsp_y1(r1_rsp_y1), .rsp_err(r1_rsp_err)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid), .req_ready(r4_req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_shift(req_shift),
    .req_imm(req_imm), .alu_a(r4_alu_a), .alu_b(r4_alu_b), .alu_ctrl(r4_alu_ctrl),
    .alu_shift(r4_alu_shift), .alu_imm(r4_alu_imm), .alu_busy(r4_alu_busy),
    .alu_y(r4_y), .alu_y1(r4_y1), .rsp_valid(r4_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(r4_rsp_y), .rsp_y1(r4_rsp_y1), .rsp_err(r4_rsp_err)
  );

  typedef struct {
    int          port;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [5:0]  ctrl;
    logic [15:0] imm;
    logic [4:0]  ey;
    logic [4:0]  ey1;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [4:0] y;
    logic [4:0] y1;
    logic       err;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic [4:0] a, input logic [4:0] b,
                            input logic [5:0] ctrl, input logic [5:0] sh, input logic [15:0] imm);
    if (p == 0) begin
      req_a[4:0] = a; req_b[4:0] = b; req_ctrl[5:0] = ctrl;
      req_shift[5:0] = sh; req_imm[15:0] = imm; req_valid[0] = 1'b1;
    end else begin
      req_a[9:5] = a; req_b[9:5] = b; req_ctrl[11:6] = ctrl;
      req_shift[11:6] = sh; req_imm[31:16] = imm; req_valid[1] = 1'b1;
    end
  endtask

  task automatic push_exp(input logic [4:0] y, input logic [4:0] y1, input logic err);
    exp_t e;
    e.y = y; e.y1 = y1; e.err = err;
    sb.push_back(e);
  endtask

  // Handshake one request on dut1, wait for its response, optionally backpressure it
  task automatic serve(input int p, input int hold, input bit drop_valid,
                       input int lat_exp, input int busy_exp, input logic [15:0] imm_exp);
    logic [1:0] oh;
    exp_t       e;
    int         n;
    int         busy;
    oh = (p == 0) ? 2'b01 : 2'b10;
    #1;
    chk("req_ready_grant", r1_req_ready, oh);
    tick();
    if (drop_valid) req_valid[p] = 1'b0;
    n = 0;
    busy = 0;
    while (r1_rsp_valid == 2'b00 && n < 40) begin
      if (r1_alu_busy) begin
        busy++;
        chk("alu_imm_busy", r1_alu_imm, imm_exp);
      end
      tick();
      n++;
    end
    chk("rsp_latency", n, lat_exp);
    chk("busy_cycles", busy, busy_exp);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got response, want nothing queued");
      e.y = 5'd0; e.y1 = 5'd0; e.err = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_valid_owner", r1_rsp_valid, oh);
    chk("rsp_y", r1_rsp_y, e.y);
    chk("rsp_y1", r1_rsp_y1, e.y1);
    chk("rsp_err", r1_rsp_err, e.err);
    for (int k = 0; k < hold; k++) begin
      rsp_ready = ~oh;
      tick();
      chk("hold_rsp_valid", r1_rsp_valid, oh);
      chk("hold_rsp_y", r1_rsp_y, e.y);
      chk("hold_rsp_y1", r1_rsp_y1, e.y1);
      chk("hold_req_ready", r1_req_ready, 2'b00);
    end
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    chk("rsp_valid_cleared", r1_rsp_valid, 2'b00);
  endtask

  task automatic pulse_rst1();
    req_valid = 2'b00;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int busy;
    rst1 = 1'b1; rst4 = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_ctrl = '0; req_shift = '0; req_imm = '0;
    #2;
    chk("rst_req_ready", r1_req_ready, 2'b00);
    chk("rst_rsp_valid", r1_rsp_valid, 2'b00);
    chk("rst_alu_busy", r1_alu_busy, 1'b0);
    chk("rst_alu_a", r1_alu_a, 5'd0);
    chk("rst_alu_imm", r1_alu_imm, 16'd0);
    chk("rst_rsp_err", r1_rsp_err, 1'b0);

    tbl[0] = '{0, 5'd2,  5'd1,  6'b000000, 16'h000C, 5'd3,  5'd1,  1'b0};
    tbl[1] = '{1, 5'd31, 5'd1,  6'b000101, 16'h1111, 5'd0,  5'd30, 1'b0};
    tbl[2] = '{1, 5'd5,  5'd7,  6'b000111, 16'h2222, 5'd0,  5'd0,  1'b1};
    tbl[3] = '{0, 5'd10, 5'd20, 6'b001010, 16'h3333, 5'd30, 5'd22, 1'b0};
    tbl[4] = '{1, 5'd17, 5'd16, 6'b001011, 16'h4444, 5'd1,  5'd1,  1'b0};
    tbl[5] = '{0, 5'd0,  5'd0,  6'b001000, 16'h5555, 5'd0,  5'd0,  1'b1};
    tbl[6] = '{0, 5'd9,  5'd4,  6'b000110, 16'h6666, 5'd13, 5'd5,  1'b0};
    tbl[7] = '{1, 5'd3,  5'd3,  6'b111111, 16'h7777, 5'd0,  5'd0,  1'b1};

    pulse_rst1();
    for (int i = 0; i < 8; i++) begin
      drive_port(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].ctrl, 6'(i + 1), tbl[i].imm);
      push_exp(tbl[i].ey, tbl[i].ey1, tbl[i].eerr);
      serve(tbl[i].port, 0, 1'b1, tbl[i].eerr ? 1 : 2, tbl[i].eerr ? 0 : 1, tbl[i].imm);
    end

    // Both ports held valid: port0, port1, port0
    pulse_rst1();
    drive_port(0, 5'd2, 5'd1, 6'b000000, 6'd1, 16'h000C);
    drive_port(1, 5'd31, 5'd1, 6'b000101, 6'd0, 16'h1234);
    push_exp(5'd3, 5'd1, 1'b0);
    serve(0, 0, 1'b0, 2, 1, 16'h000C);
    push_exp(5'd0, 5'd30, 1'b0);
    serve(1, 0, 1'b0, 2, 1, 16'h1234);
    push_exp(5'd3, 5'd1, 1'b0);
    serve(0, 0, 1'b0, 2, 1, 16'h000C);
    req_valid = 2'b00;

    // Backpressure on port0 with port1 pending
    pulse_rst1();
    drive_port(0, 5'd6, 5'd2, 6'b000001, 6'd3, 16'h00AA);
    drive_port(1, 5'd1, 5'd2, 6'b000010, 6'd4, 16'h0055);
    push_exp(5'd8, 5'd4, 1'b0);
    serve(0, 5, 1'b1, 2, 1, 16'h00AA);
    push_exp(5'd3, 5'd31, 1'b0);
    serve(1, 0, 1'b1, 2, 1, 16'h0055);

    // Reset in the second EXEC cycle of a SETTLE_CYCLES=4 instance
    rst1 = 1'b1;
    req_valid = 2'b00;
    tick();
    rst4 = 1'b0;
    tick();
    drive_port(0, 5'd5, 5'd3, 6'b000000, 6'd0, 16'h0F0F);
    #1;
    chk("s4_req_ready0", r4_req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("s4_busy_exec1", r4_alu_busy, 1'b1);
    tick();
    chk("s4_busy_exec2", r4_alu_busy, 1'b1);
    req_valid = 2'b11;
    rst4 = 1'b1;
    #1;
    chk("s4_rst_req_ready", r4_req_ready, 2'b00);
    chk("s4_rst_busy", r4_alu_busy, 1'b0);
    chk("s4_rst_alu_a", r4_alu_a, 5'd0);
    chk("s4_rst_alu_b", r4_alu_b, 5'd0);
    chk("s4_rst_alu_ctrl", r4_alu_ctrl, 6'd0);
    chk("s4_rst_alu_shift", r4_alu_shift, 6'd0);
    chk("s4_rst_alu_imm", r4_alu_imm, 16'd0);
    chk("s4_rst_rsp_valid", r4_rsp_valid, 2'b00);
    chk("s4_rst_rsp_y", r4_rsp_y, 5'd0);
    chk("s4_rst_rsp_y1", r4_rsp_y1, 5'd0);
    chk("s4_rst_rsp_err", r4_rsp_err, 1'b0);
    req_valid = 2'b00;
    tick();
    tick();
    rst4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("s4_no_rsp", r4_rsp_valid, 2'b00);
    end
    drive_port(1, 5'd7, 5'd9, 6'b000001, 6'd2, 16'h4321);
    #1;
    chk("s4_req_ready1", r4_req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    n = 0;
    busy = 0;
    while (r4_rsp_valid == 2'b00 && n < 40) begin
      if (r4_alu_busy) busy++;
      tick();
      n++;
    end
    chk("s4_latency", n, 5);
    chk("s4_busy_cycles", busy, 4);
    chk("s4_rsp_valid", r4_rsp_valid, 2'b10);
    chk("s4_rsp_y", r4_rsp_y, 5'd16);
    chk("s4_rsp_y1", r4_rsp_y1, 5'd30);
    chk("s4_rsp_err", r4_rsp_err, 1'b0);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("s4_rsp_cleared", r4_rsp_valid, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
